// File: rtl/io_out_fifo_pkg.sv
// Shared constants and helpers for the CPU output FIFO peripheral.
package io_out_fifo_pkg;

    localparam int unsigned IO_DATA_W     = 8;
    localparam int unsigned IO_FIFO_DEPTH = 4;

    // Pointer width for a power-of-two depth: ceil(log2(depth)).
    function automatic int unsigned io_aw(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/io_fifo_mem.sv
// DEPTH x WIDTH storage for the output FIFO: synchronous write, combinational read.
module io_fifo_mem
    import io_out_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = IO_DATA_W,
    parameter int unsigned DEPTH = IO_FIFO_DEPTH,
    parameter int unsigned AW    = io_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/io_out_fifo.sv
// CPU output FIFO with valid/ready drain side and full/empty/count status.
// IO_OUT_OVF_STICKY_EN enables the sticky overflow flag; otherwise ovf is 0.
module io_out_fifo
    import io_out_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = IO_DATA_W,
    parameter int unsigned DEPTH = IO_FIFO_DEPTH,
    parameter int unsigned AW    = io_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             ovf,
    input  logic             ovf_clr
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          push;
    logic          pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign out_valid = ~empty;
    assign count     = count_q;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign pop  = out_valid & out_ready;
    assign push = cpu_we & (~full | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    io_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (cpu_wd),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

`ifdef IO_OUT_OVF_STICKY_EN
    logic drop;
    logic ovf_q;

    assign drop = cpu_we & full & ~pop;

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       ovf_q <= 1'b0;
        else if (drop)    ovf_q <= 1'b1;
        else if (ovf_clr) ovf_q <= 1'b0;
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_io_out_fifo.sv
// Directed self-checking bench for io_out_fifo (either IO_OUT_OVF_STICKY_EN build).
module tb_io_out_fifo;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 2;
`ifdef IO_OUT_OVF_STICKY_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          cpu_we;
    logic [W-1:0]  cpu_wd;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          ovf;
    logic          ovf_clr;

    int errors;
    int checks;

    io_out_fifo #(
        .WIDTH (8),
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_wd    (cpu_wd),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_idle(input logic [W-1:0] d);
        cpu_we = 1'b1;
        cpu_wd = d;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cpu_we = 1'b0; cpu_wd = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) tick();
        #2 reset = 1'b1;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_single();
        cpu_we = 1'b1; cpu_wd = 8'hA5; out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got=%b exp=0", out_valid); end
        tick();
        cpu_we = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", out_data); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_pop_count got=%0d exp=0", count); end
    endtask

    task automatic fill4();
        logic [W-1:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_idle(vals[i]);
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] exp [4];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        fill4();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                errors++;
                $display("FAIL drain_%0d got valid=%b data=%h exp valid=1 data=%h", i, out_valid, out_data, exp[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_overflow();
        fill4();
        push_idle(8'h55);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", count); end
        checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL ovf_head got=%h exp=11", out_data); end
        checks++; if (ovf !== OVF_EN) begin errors++; $display("FAIL ovf_set got=%b exp=%b", ovf, OVF_EN); end
        tick();
        checks++; if (ovf !== OVF_EN) begin errors++; $display("FAIL ovf_sticky got=%b exp=%b", ovf, OVF_EN); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
        cpu_we = 1'b1; cpu_wd = 8'h77; ovf_clr = 1'b1;
        tick();
        cpu_we = 1'b0; ovf_clr = 1'b0;
        checks++; if (ovf !== OVF_EN) begin errors++; $display("FAIL ovf_set_wins got=%b exp=%b", ovf, OVF_EN); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear2 got=%b exp=0", ovf); end
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] exp [4];
        exp = '{8'h22, 8'h33, 8'h44, 8'h66};
        cpu_we = 1'b1; cpu_wd = 8'h66; out_ready = 1'b1;
        tick();
        cpu_we = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpp_count got=%0d exp=4", count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got=%b exp=0", ovf); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                errors++;
                $display("FAIL fullpp_drain_%0d got valid=%b data=%h exp valid=1 data=%h", i, out_valid, out_data, exp[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fullpp_empty got=%b exp=1", empty); end
    endtask

    task automatic test_ready_empty();
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL ready_empty got count=%0d valid=%b exp count=0 valid=0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cpu_we = 1'b1; cpu_wd = 8'(i);
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'(i - 1)) begin
                    errors++;
                    $display("FAIL b2b_data_%0d got valid=%b data=%h exp valid=1 data=%h", i, out_valid, out_data, 8'(i - 1));
                end
            end
            tick();
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count_%0d got=%0d exp=1", i, count); end
        end
        cpu_we = 1'b0;
        checks++; if (out_data !== 8'h09) begin errors++; $display("FAIL b2b_last got=%h exp=09", out_data); end
        tick();
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        push_idle(8'h01);
        push_idle(8'h02);
        push_idle(8'h03);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
        #2 reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_reset_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
        tick();
        #2 reset = 1'b1;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_after_empty got=%b exp=1", empty); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_ready_empty();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
